rpc_dram_responder: RTL
=======================

// Module: rpc_dram_responder
// PURPOSE
//  Device-side end of the RPC DRAM link, the counterpart of the rpc controller: decodes command
//  packets from the controller's CS/STB/DB pins, tracks open rows per bank, and serves read/write
//  bursts against an external 16-bit SRAM port.
//  Used as a synthesizable DRAM stand-in for FPGA emulation and as the closed-loop bench partner.
//  Link is sampled single-rate on clk_i: one 16-bit DB beat per cycle.
// PARAMETERS
//  NumBanks   4  banks tracked (BankW = $clog2(NumBanks) = 2)
//  RowWidth  10  row address bits
//  ColWidth  10  column (256-bit word) address bits
//  DefaultRL  4  reset read latency, cycles from RD accept to first data beat (legal 2..15)
//  DefaultWL  2  reset write latency, cycles from WR accept to first mask beat (legal 1..15)
//  AddrW      BankW+RowWidth+ColWidth+4  derived SRAM beat address width
// PORTS
//  clk_i         in   1      clock
//  rst_ni        in   1      async reset, active low
//  rpc_cs_ni     in   1      chip select, active low
//  rpc_stb_i     in   1      command strobe
//  phy_db_i      in   16     DB from controller
//  phy_db_o      out  16     DB to controller (read data)
//  phy_db_oe_o   out  1      DB output enable
//  phy_dqs_o     out  1      read strobe
//  phy_dqs_oe_o  out  1      DQS output enable
//  mem_req_o     out  1      SRAM access strobe
//  mem_we_o      out  1      SRAM write
//  mem_addr_o    out  AddrW  {bank,row,col,beat[3:0]}
//  mem_wdata_o   out  16     SRAM write data
//  mem_be_o      out  2      SRAM byte enables
//  mem_rdata_i   in   16     SRAM read data, valid 1 cycle after read req
//  busy_o        out  1      not in IDLE
//  err_o         out  1      1-cycle protocol error pulse
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all banks closed, RL/WL = DefaultRL/DefaultWL.
//  - Command: IDLE, cs_n=0, stb=1 captures W0; next cycle (CMD1) captures W1, stb ignored there.
//    W0 = {op[15:12], bank[11:10], row[9:0]}; W1 = {col[15:6], len[5:0]}; burst = len+1 words.
//    op: 1 ACT, 2 WR, 3 RD, 4 PRE, 5 REF, 6 MRS(W1[7:4]=RL, W1[3:0]=WL); others -> err_o, ignored.
//  - ACT: open bank with row (ACT on open bank -> err, row replaced). PRE: close bank (closed: no-op).
//    REF with any bank open -> err. RD/WR on closed bank -> err, ignored. RD/WR use open row,
//    W0 row field ignored. All accepted in CMD1, return to IDLE next cycle unless RD/WR.
//  - WR: WR_WAIT WL-1 cycles, WR_MASK 2 beats (beat0 = mask bytes 0-15, beat1 = 16-31; 1=masked),
//    WR_DATA 16 beats; beat k: mem_req=we=1, wdata=phy_db_i, be=~mask[2k+1:2k], same cycle.
//    Mask+data repeat per word; col increments, wraps 2^ColWidth-1 -> 0 within row.
//  - RD: RD_WAIT; mem read issued one cycle before each beat; phy_dqs_oe_o rises at beat -1
//    (preamble, dqs=0); first beat exactly RL cycles after the CMD1 cycle; RD_DATA drives
//    16*(len+1) beats back-to-back, phy_db_oe_o=1, phy_dqs_o=~beat[0] (1 on even beats);
//    OEs drop the cycle after last beat.
//  - cs_n rises during any WR/RD phase: abort to IDLE next cycle, err pulse, OEs low, partial
//    writes already issued stay written.
//  - stb during WR/RD phases ignored (no queueing). Async reset mid-burst: immediate IDLE,
//    OEs low, banks closed.
//  - Counters: beat 4b, word 6b, latency 4b; no arithmetic overflow beyond stated wrap.
// STRUCTURE
//  - rpc_ctrl_pkg gains rpc_op_e opcode enum and rpc_resp_state_e
//    {IDLE,CMD1,WR_WAIT,WR_MASK,WR_DATA,RD_WAIT,RD_DATA}.
//  - One sub-module: rpc_bank_tracker (per-bank open flag + row regs; act/pre/query ports).
// TESTING
//  - Reset then idle: all outputs 0, busy_o=0 for 20 cycles with cs_n=1.
//  - ACT b1 r0x2A, WR b1 col 5 len 0, mask 0x0000_0003, data 0x1000..0x100F
//    -> beat0 be=2'b00, beats1-15 be=2'b11 at addr {1,0x2A,5,k}.
//  - RD same, RL=4 -> dqs_oe at +3, data 0x1000.. from +4, dqs 1,0,1..., 16 beats, OEs low after.
//  - RD col 0x3FF len 1 -> second word addresses col 0 (wrap), 32 beats contiguous.
//  - RD on closed bank 2, REF with bank1 open, op 0xF -> one err pulse each, no mem_req.
//  - MRS RL=7 WL=3 then RD/WR -> first read beat at +7, first mask beat at +3;
//    cs_n high mid-RD -> err, IDLE.

Source files
------------

// File: rtl/rpc_dram_responder_pkg.sv
// Shared types for the RPC DRAM link: command opcodes and responder FSM states.
package rpc_ctrl_pkg;

  // Fixed burst geometry: a 256-bit word moves as 2 mask beats + 16 data beats.
  localparam int RpcMaskBeats = 2;
  localparam int RpcDataBeats = 16;

  typedef enum logic [3:0] {
    OP_ACT = 4'd1,
    OP_WR  = 4'd2,
    OP_RD  = 4'd3,
    OP_PRE = 4'd4,
    OP_REF = 4'd5,
    OP_MRS = 4'd6
  } rpc_op_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD1,
    WR_WAIT,
    WR_MASK,
    WR_DATA,
    RD_WAIT,
    RD_DATA
  } rpc_resp_state_e;

endpackage

// File: rtl/rpc_bank_tracker.sv
// Per-bank open flag and open-row register, with a single query port.
module rpc_bank_tracker #(
  parameter int  NumBanks = 4,
  parameter int  RowWidth = 10,
  localparam int BankW    = $clog2(NumBanks)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_act,
  input  logic                i_pre,
  input  logic [BankW-1:0]    i_bank,
  input  logic [RowWidth-1:0] i_row,
  output logic                o_open,
  output logic [RowWidth-1:0] o_row,
  output logic                o_any_open
);

  logic [NumBanks-1:0]               r_open;
  logic [NumBanks-1:0][RowWidth-1:0] r_row;

  // ACT opens (or re-opens with a new row); PRE closes. Closing a closed bank is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_open <= '0;
      r_row  <= '0;
    end else if (i_act) begin
      r_open[i_bank] <= 1'b1;
      r_row[i_bank]  <= i_row;
    end else if (i_pre) begin
      r_open[i_bank] <= 1'b0;
    end
  end

  assign o_open     = r_open[i_bank];
  assign o_row      = r_row[i_bank];
  assign o_any_open = |r_open;

endmodule

// File: rtl/rpc_dram_responder.sv
// Device side of the RPC DRAM link: decodes two-word commands, tracks open rows and
// serves masked write / latency-timed read bursts against a 16-bit SRAM port.
module rpc_dram_responder
  import rpc_ctrl_pkg::*;
#(
  parameter int  NumBanks  = 4,
  parameter int  RowWidth  = 10,
  parameter int  ColWidth  = 10,
  parameter int  DefaultRL = 4,
  parameter int  DefaultWL = 2,
  localparam int BankW     = $clog2(NumBanks),
  localparam int AddrW     = BankW + RowWidth + ColWidth + 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rpc_cs_ni,
  input  logic             rpc_stb_i,
  input  logic [15:0]      phy_db_i,
  output logic [15:0]      phy_db_o,
  output logic             phy_db_oe_o,
  output logic             phy_dqs_o,
  output logic             phy_dqs_oe_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [15:0]      mem_wdata_o,
  output logic [1:0]       mem_be_o,
  input  logic [15:0]      mem_rdata_i,
  output logic             busy_o,
  output logic             err_o
);

  rpc_resp_state_e r_state, w_nxt_state;

  logic [15:0]          r_w0;
  logic [BankW-1:0]     r_bank;
  logic [RowWidth-1:0]  r_row;
  logic [ColWidth-1:0]  r_col;
  logic [5:0]           r_len, r_word;
  logic [3:0]           r_beat, r_lat, r_rl, r_wl;
  logic [31:0]          r_mask;

  logic [3:0]           w_op;
  logic [BankW-1:0]     w_cmd_bank;
  logic                 w_bank_open, w_any_open;
  logic [RowWidth-1:0]  w_open_row;
  logic                 w_act, w_pre, w_err, w_abort, w_last_beat, w_last_word;
  logic                 w_req, w_we, w_db_oe, w_dqs_oe, w_dqs;
  logic [1:0]           w_be;
  logic [15:0]          w_wdata;
  logic [ColWidth-1:0]  w_addr_col;
  logic [3:0]           w_addr_beat;
  logic [1:0]           w_beat_mask;
  logic [3:0]           w_mrs_rl, w_mrs_wl;

  assign w_op        = r_w0[15:12];
  assign w_cmd_bank  = r_w0[10 +: BankW];
  assign w_last_beat = (r_beat == 4'hF);
  assign w_last_word = (r_word == r_len);
  assign w_beat_mask = r_mask[{r_beat, 1'b0} +: 2];
  assign w_abort     = rpc_cs_ni && (r_state != IDLE) && (r_state != CMD1);
  // Out-of-range latencies are pulled to the nearest legal value so the counters never wrap.
  assign w_mrs_rl    = (phy_db_i[7:4] < 4'd2) ? 4'd2 : phy_db_i[7:4];
  assign w_mrs_wl    = (phy_db_i[3:0] == 4'd0) ? 4'd1 : phy_db_i[3:0];

  rpc_bank_tracker #(.NumBanks(NumBanks), .RowWidth(RowWidth)) u_banks (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_act      (w_act),
    .i_pre      (w_pre),
    .i_bank     (w_cmd_bank),
    .i_row      (r_w0[RowWidth-1:0]),
    .o_open     (w_bank_open),
    .o_row      (w_open_row),
    .o_any_open (w_any_open)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_nxt_state;
  end

  // Next state plus all link/SRAM outputs; a cs_n abort overrides everything at the end.
  always_comb begin
    w_nxt_state = r_state;
    w_act       = 1'b0;
    w_pre       = 1'b0;
    w_err       = 1'b0;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_be        = 2'b00;
    w_wdata     = '0;
    w_addr_col  = r_col;
    w_addr_beat = r_beat;
    w_db_oe     = 1'b0;
    w_dqs_oe    = 1'b0;
    w_dqs       = 1'b0;
    case (r_state)
      IDLE: if (!rpc_cs_ni && rpc_stb_i) w_nxt_state = CMD1;
      CMD1: begin
        w_nxt_state = IDLE;
        case (w_op)
          OP_ACT: begin w_act = 1'b1; w_err = w_bank_open; end
          OP_PRE: w_pre = 1'b1;
          OP_REF: w_err = w_any_open;
          OP_MRS: w_err = 1'b0;
          OP_WR:  if (w_bank_open) w_nxt_state = (r_wl == 4'd1) ? WR_MASK : WR_WAIT;
                  else             w_err = 1'b1;
          OP_RD:  if (w_bank_open) w_nxt_state = RD_WAIT;
                  else             w_err = 1'b1;
          default: w_err = 1'b1;
        endcase
      end
      WR_WAIT: if (r_lat == 4'd0) w_nxt_state = WR_MASK;
      WR_MASK: if (r_beat[0]) w_nxt_state = WR_DATA;
      WR_DATA: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_wdata = phy_db_i;
        w_be    = ~w_beat_mask;
        if (w_last_beat) w_nxt_state = w_last_word ? IDLE : WR_MASK;
      end
      RD_WAIT: if (r_lat == 4'd0) begin
        // Preamble cycle: DQS enabled low, SRAM fetch for beat 0 in flight.
        w_dqs_oe    = 1'b1;
        w_req       = 1'b1;
        w_addr_beat = 4'd0;
        w_nxt_state = RD_DATA;
      end
      RD_DATA: begin
        w_db_oe  = 1'b1;
        w_dqs_oe = 1'b1;
        w_dqs    = ~r_beat[0];
        if (w_last_beat && w_last_word) begin
          w_nxt_state = IDLE;
        end else begin
          // Prefetch the next beat, rolling into the next column at a word boundary.
          w_req       = 1'b1;
          w_addr_col  = w_last_beat ? r_col + 1'b1 : r_col;
          w_addr_beat = r_beat + 4'd1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
    if (w_abort) begin
      w_nxt_state = IDLE;
      w_err       = 1'b1;
      w_req       = 1'b0;
      w_we        = 1'b0;
      w_be        = 2'b00;
      w_wdata     = '0;
      w_db_oe     = 1'b0;
      w_dqs_oe    = 1'b0;
      w_dqs       = 1'b0;
    end
  end

  // Command capture, burst counters, write mask and mode registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w0   <= '0;
      r_bank <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_len  <= '0;
      r_word <= '0;
      r_beat <= '0;
      r_lat  <= '0;
      r_mask <= '0;
      r_rl   <= 4'(DefaultRL);
      r_wl   <= 4'(DefaultWL);
    end else begin
      case (r_state)
        IDLE: if (!rpc_cs_ni && rpc_stb_i) r_w0 <= phy_db_i;
        CMD1: begin
          r_col  <= phy_db_i[6 +: ColWidth];
          r_len  <= phy_db_i[5:0];
          r_word <= '0;
          r_beat <= '0;
          r_bank <= w_cmd_bank;
          r_row  <= w_open_row;
          // Remaining wait cycles after CMD1 before the preamble / first mask beat.
          if (w_op == OP_RD) r_lat <= r_rl - 4'd2;
          else               r_lat <= (r_wl >= 4'd2) ? r_wl - 4'd2 : 4'd0;
          if (w_op == OP_MRS) begin
            r_rl <= w_mrs_rl;
            r_wl <= w_mrs_wl;
          end
        end
        WR_WAIT, RD_WAIT: if (r_lat != 4'd0) r_lat <= r_lat - 4'd1;
        WR_MASK: begin
          if (r_beat[0]) r_mask[31:16] <= phy_db_i;
          else           r_mask[15:0]  <= phy_db_i;
          r_beat <= r_beat[0] ? 4'd0 : 4'd1;
        end
        WR_DATA, RD_DATA: begin
          r_beat <= r_beat + 4'd1;
          if (w_last_beat && !w_last_word) begin
            r_col  <= r_col + 1'b1;
            r_word <= r_word + 6'd1;
          end
        end
        default: r_beat <= r_beat;
      endcase
    end
  end

  assign phy_db_o     = w_db_oe ? mem_rdata_i : '0;
  assign phy_db_oe_o  = w_db_oe;
  assign phy_dqs_o    = w_dqs;
  assign phy_dqs_oe_o = w_dqs_oe;
  assign mem_req_o    = w_req;
  assign mem_we_o     = w_we;
  assign mem_addr_o   = w_req ? {r_bank, r_row, w_addr_col, w_addr_beat} : '0;
  assign mem_wdata_o  = w_wdata;
  assign mem_be_o     = w_be;
  assign busy_o       = (r_state != IDLE);
  assign err_o        = w_err;

endmodule
